// File: rtl/nx_mimosa_pkg.sv
// Shared datapath dimensions and operand payload types for the IMM filter blocks.
package nx_mimosa_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STATE_DIM  = 4;

  // Vector of STATE_DIM elements; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
  typedef logic [STATE_DIM*DATA_WIDTH-1:0] vec_t;
  // Row-major STATE_DIM x STATE_DIM matrix; element (i,j) at (i*STATE_DIM+j)*DATA_WIDTH.
  typedef logic [STATE_DIM*STATE_DIM*DATA_WIDTH-1:0] mat_t;

endpackage

// File: rtl/mv_mult_scheduler_if.sv
// Requester-side bus of the shared matrix-vector engine scheduler.
//   req_valid/req_ready : per-requester request and one-hot grant pulse
//   req_m/req_x         : packed operands, requester r at slot r
//   rsp_valid/rsp_y/rsp_err : one-hot result pulse, result vector, timeout flag
// Modports: master = requester side, slave = scheduler side.
interface mv_mult_scheduler_if #(
  parameter int unsigned N_REQ = 3
) ();

  localparam int unsigned MW = $bits(nx_mimosa_pkg::mat_t);
  localparam int unsigned VW = $bits(nx_mimosa_pkg::vec_t);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*MW-1:0] req_m;
  logic [N_REQ*VW-1:0] req_x;
  logic [N_REQ-1:0]    rsp_valid;
  logic [VW-1:0]       rsp_y;
  logic                rsp_err;

  modport master (
    output req_valid, req_m, req_x,
    input  req_ready, rsp_valid, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_m, req_x,
    output req_ready, rsp_valid, rsp_y, rsp_err
  );

endinterface

// File: rtl/mv_mult_scheduler.sv
// Round-robin scheduler sharing one matrix_vector_mult engine among N_REQ
// requesters: arbitrates, captures the winner's operands, runs the engine
// start/done handshake, returns y to the winner and aborts on a done timeout.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req_if (slave) : requester request/grant, operands, one-hot response
//   mv_start/mv_m/mv_x : engine start pulse and registered operands
//   mv_y/mv_done   : engine result and completion pulse
//   busy           : scheduler not idle
//   err_cnt        : saturating count of timeout aborts
module mv_mult_scheduler
  import nx_mimosa_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mv_mult_scheduler_if.slave   req_if,
  output logic                 mv_start,
  output mat_t                 mv_m,
  output vec_t                 mv_x,
  input  vec_t                 mv_y,
  input  logic                 mv_done,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned MW    = $bits(mat_t);
  localparam int unsigned VW    = $bits(vec_t);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]     req_ready_q, req_ready_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  vec_t                 rsp_y_q, rsp_y_d;
  logic                 mv_start_q, mv_start_d;
  mat_t                 mv_m_q, mv_m_d;
  vec_t                 mv_x_q, mv_x_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;

  // Round-robin pick: first valid requester scanning last+1, last+2, ... mod N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!grant_found && req_if.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_y_d     = rsp_y_q;
    mv_start_d  = 1'b0;
    mv_m_d      = mv_m_q;
    mv_x_d      = mv_x_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d     = ISSUE;
          last_d      = grant_idx;
          owner_d     = grant_idx;
          req_ready_d = N_REQ'(1) << grant_idx;
          // Start is registered here so it is high exactly during ISSUE.
          mv_start_d  = 1'b1;
          mv_m_d      = req_if.req_m[32'(grant_idx) * MW +: MW];
          mv_x_d      = req_if.req_x[32'(grant_idx) * VW +: VW];
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Done is checked first so a done on the timeout cycle still succeeds.
        if (mv_done) begin
          rsp_y_d     = mv_y;
          rsp_valid_d = N_REQ'(1) << owner_q;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_y_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = N_REQ'(1) << owner_q;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(N_REQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_y_q     <= '0;
      mv_start_q  <= 1'b0;
      mv_m_q      <= '0;
      mv_x_q      <= '0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_y_q     <= rsp_y_d;
      mv_start_q  <= mv_start_d;
      mv_m_q      <= mv_m_d;
      mv_x_q      <= mv_x_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.rsp_y     = rsp_y_q;
  assign mv_start         = mv_start_q;
  assign mv_m             = mv_m_q;
  assign mv_x             = mv_x_q;
  assign busy             = busy_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: doc/mv_mult_scheduler.md
Name: mv_mult_scheduler

Overview:
Round-robin scheduler that shares one matrix_vector_mult engine (y = M·x, STATE_DIM×STATE_DIM by STATE_DIM) between N_REQ requesters, such as the IMM model filters. It arbitrates requests and captures the winner's operands. It sequences the engine start/done handshake, returns y to the winner, and aborts on a done timeout. It sits between the IMM predict/update sequencers and the single shared engine instance.

Parameters:
N_REQ, 3, number of requesters (2..8)
TIMEOUT_CYC, 16, max WAIT cycles for mv_done before abort (≥4)
ERR_CNT_W, 8, width of saturating timeout counter
(DATA_WIDTH, STATE_DIM come from nx_mimosa_pkg; D = DATA_WIDTH, S = STATE_DIM below)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request; held until req_ready
req_ready  out  N_REQ  one-hot 1-cycle grant/accept pulse
req_m  in  N_REQ*S*S*D  matrices; requester r at offset r*S*S*D; element (i,j) at (i*S+j)*D
req_x  in  N_REQ*S*D  vectors; requester r at offset r*S*D; element j at j*D
rsp_valid  out  N_REQ  one-hot 1-cycle result pulse to the original requester
rsp_y  out  S*D  result vector; valid only while rsp_valid != 0
rsp_err  out  1  qualifies rsp_valid: 1 = timeout abort
mv_start  out  1  engine start pulse
mv_m  out  S*S*D  engine matrix operand (registered)
mv_x  out  S*D  engine vector operand (registered)
mv_y  in  S*D  engine result
mv_done  in  1  engine completion pulse
busy  out  1  state != IDLE
err_cnt  out  ERR_CNT_W  saturating count of timeouts

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. The engine's rst_n is tied to ~rst at integration.
- Reset values: state = IDLE. req_ready, rsp_valid, rsp_err, mv_start, busy = 0. rsp_y, mv_m, mv_x = 0. err_cnt = 0. RR pointer last = N_REQ-1, so requester 0 wins first.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, cycle t, any req_valid = 1:
  - Winner = first set bit scanning last+1, last+2, … mod N_REQ.
  - At the edge: latch that requester's M and x into mv_m/mv_x, set last = winner, record owner, go to ISSUE.
  - In cycle t+1: req_ready[winner] = 1.
- ISSUE (cycle t+1): mv_start = 1 for exactly this cycle. Clear timeout counter. Next state WAIT.
- WAIT: timeout counter increments each cycle.
  - mv_done = 1: latch mv_y into rsp_y, rsp_err = 0, go to IDLE. Next cycle rsp_valid[owner] = 1.
  - Counter reaches TIMEOUT_CYC with mv_done = 0: rsp_y = 0, rsp_err = 1, rsp_valid[owner] = 1 next cycle, err_cnt += 1 (saturates at all-ones), go to IDLE.
  - mv_done and timeout in the same cycle: done wins, no error.
- Responses have no backpressure. rsp_valid and rsp_err last exactly one cycle.
- Back-to-back: IDLE in the same cycle as rsp_valid may grant again. Nominal latency with the real engine: request at t → start at t+1 → mv_done at t+4 → rsp_valid at t+5. The scheduler does not rely on the engine's exact latency.
- mv_done outside WAIT is ignored.
- mv_m/mv_x hold their value from grant until the next grant.
- Requester rules:
  - M and x must be stable while req_valid = 1; they are sampled only at the grant edge.
  - Dropping req_valid before the grant withdraws the request, with no side effects.
  - Holding req_valid after req_ready = 1 is a new request.
- Non-winners keep waiting; their req_valid is not consumed.
- rst asserted in any state: next cycle all reset values apply; an in-flight operation is discarded, with no rsp_valid.
- No arithmetic is performed. Operand and result bits pass through unmodified.

Test Plan:
- Single request: rst 2 cycles, then req_valid = 3'b001 with M = I (diagonal = 1<<FRAC_BITS), x = {1,2,3,4}·2^FRAC_BITS, real engine → req_ready = 001 at t+1, mv_start at t+1 only, rsp_valid = 001 at t+5, rsp_y = x, rsp_err = 0.
- All three requesting continuously, distinct x → grant order 0,1,2,0,1,2. Each rsp_y matches its own operands; rsp_valid bit = owner.
- Fairness after last = 1, then req_valid = 3'b011 → requester 0 granted (scan starts at 2, then 0), not 1.
- Timeout: engine model never asserts mv_done → rsp_valid[owner] and rsp_err = 1 exactly TIMEOUT_CYC+1 cycles after mv_start, rsp_y = 0, err_cnt = 1. Repeat 300× → err_cnt saturates at 255.
- mv_done on the same cycle the counter hits TIMEOUT_CYC → rsp_err = 0, rsp_y = mv_y, err_cnt unchanged.
- rst asserted during WAIT, then a late mv_done → no rsp_valid, busy = 0 next cycle. A fresh request is granted to requester 0 with correct result.
